// File: rtl/interrupter_nch_pkg.sv
// Shared constants for the multi-channel interrupter: register map, ID width
// and helpers that map channel indices to IDs and priority register addresses.
package interrupter_nch_pkg;

    localparam int ID_W = 6;

    typedef logic [ID_W-1:0] irq_id_t;

    localparam irq_id_t NONE_ID = '0;

    localparam logic [5:0] ADR_ENABLE    = 6'h00;
    localparam logic [5:0] ADR_MODE      = 6'h01;
    localparam logic [5:0] ADR_THRESH    = 6'h02;
    localparam logic [5:0] ADR_PENDING   = 6'h03;
    localparam logic [5:0] ADR_INSERVICE = 6'h04;
    localparam logic [5:0] ADR_PRI_BASE  = 6'h10;

    // Channel index i is reported to software as ID i+1; ID 0 means "none".
    function automatic irq_id_t chan_id(input int idx);
        return irq_id_t'(idx + 1);
    endfunction

    function automatic logic [5:0] pri_adr(input int idx);
        return ADR_PRI_BASE + 6'(idx);
    endfunction

endpackage

// File: rtl/interrupter_nch_irq_gateway.sv
// Per-channel gateway: synchroniser, edge detect, pending and in-service flops.
// Set always beats clear so that no edge or claim is ever silently lost.
module irq_gateway (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic edge_mode,
    input  logic clr_edge,
    input  logic set_is,
    input  logic clr_is,
    output logic pending,
    output logic in_service
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            s3_reg     <= 1'b0;
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            s1_reg <= irq;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;

            if (!edge_mode) begin
                pending <= s2_reg;
            end else if (s2_reg && !s3_reg) begin
                pending <= 1'b1;
            end else if (clr_edge) begin
                pending <= 1'b0;
            end

            if (set_is) begin
                in_service <= 1'b1;
            end else if (clr_is) begin
                in_service <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/interrupter_nch.sv
// Multi-channel interrupter: config/status registers, priority arbitration and
// claim/complete handshake feeding g_interrupt / g_interrupt_1shot to the core.
module interrupter_nch
    import interrupter_nch_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int PRI_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  irq_in,
    input  logic            csr_meie,
    input  logic            interrupt_clear,
    input  logic            cfg_we,
    input  logic [5:0]      cfg_wadr,
    input  logic [31:0]     cfg_wdata,
    input  logic [5:0]      cfg_radr,
    output logic [31:0]     cfg_rdata,
    input  logic            claim_re,
    output logic [ID_W-1:0] claim_id,
    input  logic            complete_we,
    input  logic [ID_W-1:0] complete_id,
    output logic            g_interrupt,
    output logic            g_interrupt_1shot
);

    logic [NCH-1:0]   enable_reg;
    logic [NCH-1:0]   mode_reg;
    logic [PRI_W-1:0] thresh_reg;
    logic [PRI_W-1:0] pri_reg [NCH];

    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   in_service;
    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   clr_edge;
    logic [NCH-1:0]   set_is;
    logic [NCH-1:0]   clr_is;

    irq_id_t          best_id_reg;
    logic [PRI_W-1:0] best_pri_reg;
    irq_id_t          arb_id;
    logic [PRI_W-1:0] arb_pri;
    logic             g_int_next;
    logic             w1c;
    logic             claim_hit;
    logic [31:0]      rdata_next;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata;
    assign w1c          = cfg_we && (cfg_wadr == ADR_PENDING);
    // best_pri is zero exactly when best_id is NONE, so this also filters empty claims.
    assign claim_hit    = claim_re && (best_pri_reg != '0);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign eligible[gi] = pending[gi] & enable_reg[gi] & ~in_service[gi]
                            & (pri_reg[gi] != '0);
        assign set_is[gi]   = claim_hit && (best_id_reg == chan_id(gi));
        assign clr_edge[gi] = interrupt_clear | (w1c & cfg_wdata[gi]) | set_is[gi];
        assign clr_is[gi]   = complete_we && (complete_id == chan_id(gi));

        irq_gateway u_gateway (
            .clk        (clk),
            .rst_n      (rst_n),
            .irq        (irq_in[gi]),
            .edge_mode  (mode_reg[gi]),
            .clr_edge   (clr_edge[gi]),
            .set_is     (set_is[gi]),
            .clr_is     (clr_is[gi]),
            .pending    (pending[gi]),
            .in_service (in_service[gi])
        );
    end

    // Strict compare keeps the lowest index on priority ties.
    always_comb begin
        arb_id  = NONE_ID;
        arb_pri = '0;
        for (int i = 0; i < NCH; i++) begin
            if (eligible[i] && (pri_reg[i] > arb_pri)) begin
                arb_pri = pri_reg[i];
                arb_id  = chan_id(i);
            end
        end
    end

    assign g_int_next = csr_meie && (arb_pri > thresh_reg);

    always_comb begin
        rdata_next = '0;
        case (cfg_radr)
            ADR_ENABLE:    rdata_next[NCH-1:0]   = enable_reg;
            ADR_MODE:      rdata_next[NCH-1:0]   = mode_reg;
            ADR_THRESH:    rdata_next[PRI_W-1:0] = thresh_reg;
            ADR_PENDING:   rdata_next[NCH-1:0]   = pending;
            ADR_INSERVICE: rdata_next[NCH-1:0]   = in_service;
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (cfg_radr == pri_adr(i)) begin
                        rdata_next[PRI_W-1:0] = pri_reg[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_reg <= '0;
            mode_reg   <= '0;
            thresh_reg <= '0;
            for (int i = 0; i < NCH; i++) begin
                pri_reg[i] <= '0;
            end
        end else if (cfg_we) begin
            case (cfg_wadr)
                ADR_ENABLE: enable_reg <= cfg_wdata[NCH-1:0];
                ADR_MODE:   mode_reg   <= cfg_wdata[NCH-1:0];
                ADR_THRESH: thresh_reg <= cfg_wdata[PRI_W-1:0];
                default: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (cfg_wadr == pri_adr(i)) begin
                            pri_reg[i] <= cfg_wdata[PRI_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_id_reg       <= NONE_ID;
            best_pri_reg      <= '0;
            g_interrupt       <= 1'b0;
            g_interrupt_1shot <= 1'b0;
            claim_id          <= NONE_ID;
            cfg_rdata         <= '0;
        end else begin
            best_id_reg       <= arb_id;
            best_pri_reg      <= arb_pri;
            g_interrupt       <= g_int_next;
            g_interrupt_1shot <= g_int_next & ~g_interrupt;
            cfg_rdata         <= rdata_next;
            if (claim_re) begin
                claim_id <= best_id_reg;
            end
        end
    end

endmodule

// File: tb/tb_interrupter_nch.sv
// Self-checking bench for interrupter_nch: register table, hand-written timing
// sequences and randomized rounds checked against a set-based claim model.
module tb_interrupter_nch;

    localparam int NCH   = 8;
    localparam int PRI_W = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] irq_in = '0;
    logic           csr_meie = 1'b0;
    logic           interrupt_clear = 1'b0;
    logic           cfg_we = 1'b0;
    logic [5:0]     cfg_wadr = '0;
    logic [31:0]    cfg_wdata = '0;
    logic [5:0]     cfg_radr = '0;
    logic [31:0]    cfg_rdata;
    logic           claim_re = 1'b0;
    logic [5:0]     claim_id;
    logic           complete_we = 1'b0;
    logic [5:0]     complete_id = '0;
    logic           g_interrupt;
    logic           g_interrupt_1shot;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  adr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } cfg_vec_t;

    cfg_vec_t       vec [10];
    int             mpri [NCH];
    logic [31:0]    rdat;
    logic [5:0]     got_id;
    logic [NCH-1:0] r_en, r_mask, r_rem, r_claimed;
    int             r_thr, r_maxp, r_exp;
    logic           r_meie;

    interrupter_nch #(.NCH(NCH), .PRI_W(PRI_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .irq_in            (irq_in),
        .csr_meie          (csr_meie),
        .interrupt_clear   (interrupt_clear),
        .cfg_we            (cfg_we),
        .cfg_wadr          (cfg_wadr),
        .cfg_wdata         (cfg_wdata),
        .cfg_radr          (cfg_radr),
        .cfg_rdata         (cfg_rdata),
        .claim_re          (claim_re),
        .claim_id          (claim_id),
        .complete_we       (complete_we),
        .complete_id       (complete_id),
        .g_interrupt       (g_interrupt),
        .g_interrupt_1shot (g_interrupt_1shot)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        irq_in = '0;
        csr_meie = 1'b0;
        interrupt_clear = 1'b0;
        cfg_we = 1'b0;
        claim_re = 1'b0;
        complete_we = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_wadr = a;
        cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
        $display("cfg write adr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        cfg_radr = a;
        cyc(1);
        d = cfg_rdata;
    endtask

    task automatic claim(output logic [5:0] id);
        claim_re = 1'b1;
        cyc(1);
        id = claim_id;
        claim_re = 1'b0;
        $display("claim -> id=%0d", id);
    endtask

    task automatic complete(input logic [5:0] id);
        complete_we = 1'b1;
        complete_id = id;
        cyc(1);
        complete_we = 1'b0;
        $display("complete id=%0d", id);
    endtask

    task automatic pulse(input logic [NCH-1:0] m);
        irq_in = m;
        cyc(2);
        irq_in = '0;
        cyc(6);
    endtask

    // Model: highest priority wins, then the lowest-numbered channel at that priority.
    function automatic int model_best(input logic [NCH-1:0] rem);
        int maxp = 0;
        for (int i = 0; i < NCH; i++)
            if (rem[i] && mpri[i] > maxp) maxp = mpri[i];
        if (maxp == 0) return 0;
        for (int i = 0; i < NCH; i++)
            if (rem[i] && mpri[i] == maxp) return i + 1;
        return 0;
    endfunction

    initial begin
        vec[0] = '{6'h00, 32'hFFFF_FFA5, 32'h0000_00A5};
        vec[1] = '{6'h01, 32'h1234_563C, 32'h0000_003C};
        vec[2] = '{6'h02, 32'hFFFF_FFFE, 32'h0000_0006};
        vec[3] = '{6'h10, 32'hFFFF_FFFD, 32'h0000_0005};
        vec[4] = '{6'h17, 32'h0000_0003, 32'h0000_0003};
        vec[5] = '{6'h18, 32'hFFFF_FFFF, 32'h0000_0000};
        vec[6] = '{6'h05, 32'hFFFF_FFFF, 32'h0000_0000};
        vec[7] = '{6'h04, 32'h0000_00FF, 32'h0000_0000};
        vec[8] = '{6'h03, 32'h0000_00FF, 32'h0000_0000};
        vec[9] = '{6'h3F, 32'hFFFF_FFFF, 32'h0000_0000};

        // Reset state and inert sources
        do_reset();
        check("reset_gint", 32'(g_interrupt), 32'd0);
        check("reset_1shot", 32'(g_interrupt_1shot), 32'd0);
        check("reset_claim_id", 32'(claim_id), 32'd0);
        for (int a = 0; a < 64; a++) begin
            rd(6'(a), rdat);
            check($sformatf("reset_rdata_%0d", a), rdat, 32'd0);
        end
        csr_meie = 1'b1;
        for (int k = 0; k < 10; k++) begin
            irq_in = NCH'($urandom);
            cyc(1);
            check("reset_toggle_gint", 32'(g_interrupt), 32'd0);
        end
        irq_in = '0;
        cyc(4);
        claim(got_id);
        check("reset_claim_none", 32'(got_id), 32'd0);

        // Register table
        do_reset();
        for (int v = 0; v < 10; v++) begin
            wr(vec[v].adr, vec[v].wdata);
            rd(vec[v].adr, rdat);
            check($sformatf("table_adr_%02h", vec[v].adr), rdat, vec[v].exp);
        end

        // Single edge on channel 2 through the whole pipeline
        do_reset();
        wr(6'h00, 32'h04);
        wr(6'h01, 32'h04);
        wr(6'h12, 32'd3);
        csr_meie = 1'b1;
        irq_in[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            check($sformatf("ch2_gint_e%0d", k), 32'(g_interrupt), 32'(k >= 4));
            check($sformatf("ch2_1shot_e%0d", k), 32'(g_interrupt_1shot), 32'(k == 4));
            if (k == 2) irq_in[2] = 1'b0;
        end
        claim(got_id);
        check("ch2_claim", 32'(got_id), 32'd3);
        check("ch2_gint_at_claim", 32'(g_interrupt), 32'd1);
        cyc(1);
        check("ch2_gint_drop", 32'(g_interrupt), 32'd0);
        complete(6'd3);
        cyc(4);
        check("ch2_no_reraise", 32'(g_interrupt), 32'd0);
        rd(6'h04, rdat);
        check("ch2_inservice", rdat, 32'd0);

        // Priority and tie-break order
        do_reset();
        wr(6'h00, 32'h62);
        wr(6'h01, 32'h62);
        wr(6'h11, 32'd4);
        wr(6'h15, 32'd4);
        wr(6'h16, 32'd2);
        csr_meie = 1'b1;
        pulse(8'h62);
        claim(got_id); check("order_1", 32'(got_id), 32'd2); cyc(2);
        claim(got_id); check("order_2", 32'(got_id), 32'd6); cyc(2);
        claim(got_id); check("order_3", 32'(got_id), 32'd7); cyc(2);
        claim(got_id); check("order_none", 32'(got_id), 32'd0);

        // Threshold masks a low-priority source until it is lowered
        do_reset();
        wr(6'h00, 32'h40);
        wr(6'h01, 32'h40);
        wr(6'h16, 32'd2);
        wr(6'h02, 32'd3);
        csr_meie = 1'b1;
        pulse(8'h40);
        check("thresh_block", 32'(g_interrupt), 32'd0);
        rd(6'h03, rdat);
        check("thresh_pending", rdat, 32'h40);
        wr(6'h02, 32'd1);
        cyc(1);
        check("thresh_lowered", 32'(g_interrupt), 32'd1);

        // Level source: re-raise after complete, none once dropped
        do_reset();
        wr(6'h00, 32'h08);
        wr(6'h13, 32'd5);
        csr_meie = 1'b1;
        irq_in[3] = 1'b1;
        cyc(6);
        check("level_gint", 32'(g_interrupt), 32'd1);
        claim(got_id);
        check("level_claim", 32'(got_id), 32'd4);
        cyc(2);
        check("level_in_service", 32'(g_interrupt), 32'd0);
        complete(6'd4);
        check("level_at_complete", 32'(g_interrupt), 32'd0);
        cyc(1);
        check("level_reraise", 32'(g_interrupt), 32'd1);
        claim(got_id);
        check("level_claim2", 32'(got_id), 32'd4);
        irq_in[3] = 1'b0;
        cyc(5);
        complete(6'd4);
        cyc(3);
        check("level_dropped", 32'(g_interrupt), 32'd0);

        // Edge arriving in the same cycle as its claim
        do_reset();
        wr(6'h00, 32'h01);
        wr(6'h01, 32'h01);
        wr(6'h10, 32'd2);
        csr_meie = 1'b1;
        pulse(8'h01);
        check("collide_gint", 32'(g_interrupt), 32'd1);
        irq_in[0] = 1'b1;
        cyc(2);
        claim(got_id);
        check("collide_claim", 32'(got_id), 32'd1);
        irq_in[0] = 1'b0;
        cyc(3);
        check("collide_masked", 32'(g_interrupt), 32'd0);
        rd(6'h03, rdat);
        check("collide_pending", rdat, 32'h01);
        complete(6'd1);
        cyc(2);
        check("collide_reraise", 32'(g_interrupt), 32'd1);
        claim(got_id);
        check("collide_claim2", 32'(got_id), 32'd1);

        // Bad completes, pending clears, asynchronous reset mid-service
        do_reset();
        wr(6'h00, 32'h33);
        wr(6'h01, 32'hFF);
        wr(6'h10, 32'd1);
        wr(6'h11, 32'd2);
        csr_meie = 1'b1;
        pulse(8'h03);
        claim(got_id); check("bad_claim_a", 32'(got_id), 32'd2); cyc(2);
        claim(got_id); check("bad_claim_b", 32'(got_id), 32'd1);
        rd(6'h04, rdat);
        check("bad_is_before", rdat, 32'h03);
        complete(6'd0);  rd(6'h04, rdat); check("bad_complete_0", rdat, 32'h03);
        complete(6'd9);  rd(6'h04, rdat); check("bad_complete_9", rdat, 32'h03);
        complete(6'd3);  rd(6'h04, rdat); check("bad_complete_3", rdat, 32'h03);
        pulse(8'h30);
        rd(6'h03, rdat);
        check("clr_pending_set", rdat, 32'h30);
        wr(6'h03, 32'h10);
        rd(6'h03, rdat);
        check("clr_w1c", rdat, 32'h20);
        interrupt_clear = 1'b1;
        cyc(1);
        interrupt_clear = 1'b0;
        rd(6'h03, rdat);
        check("clr_interrupt_clear", rdat, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_claim_id", 32'(claim_id), 32'd0);
        cyc(1);
        rst_n = 1'b1;
        rd(6'h04, rdat);
        check("reset_mid_service", rdat, 32'd0);

        // Randomized rounds against the claim-order model
        for (int r = 0; r < 20; r++) begin
            do_reset();
            r_en   = NCH'($urandom);
            r_mask = NCH'($urandom);
            r_thr  = int'($urandom_range(0, 7));
            r_meie = ($urandom_range(0, 3) != 0);
            wr(6'h00, 32'(r_en));
            wr(6'h01, 32'hFF);
            wr(6'h02, 32'(r_thr));
            for (int i = 0; i < NCH; i++) begin
                mpri[i] = int'($urandom_range(0, 7));
                wr(6'h10 + 6'(i), 32'(mpri[i]));
            end
            csr_meie = r_meie;
            pulse(r_mask);
            rd(6'h03, rdat);
            check("rand_pending", rdat, 32'(r_mask));
            r_rem  = '0;
            r_maxp = 0;
            for (int i = 0; i < NCH; i++) begin
                if (r_mask[i] && r_en[i] && mpri[i] > 0) begin
                    r_rem[i] = 1'b1;
                    if (mpri[i] > r_maxp) r_maxp = mpri[i];
                end
            end
            check("rand_gint", 32'(g_interrupt), 32'(r_meie && (r_maxp > r_thr)));
            r_claimed = '0;
            for (int k = 0; k <= NCH; k++) begin
                r_exp = model_best(r_rem);
                claim(got_id);
                check("rand_claim", 32'(got_id), 32'(r_exp));
                if (r_exp == 0) break;
                r_rem[r_exp-1]     = 1'b0;
                r_claimed[r_exp-1] = 1'b1;
                cyc(2);
            end
            rd(6'h04, rdat);
            check("rand_inservice", rdat, 32'(r_claimed));
            check("rand_gint_idle", 32'(g_interrupt), 32'd0);
            for (int i = 0; i < NCH; i++)
                if (r_claimed[i]) complete(6'(i + 1));
            rd(6'h04, rdat);
            check("rand_inservice_done", rdat, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupter_nch.md
# interrupter_nch

Parametrised multi-channel successor to the single-source interrupter in the CPU top. It gathers NCH external interrupt sources and synchronises each one. Each source can be set to edge or level mode, with a priority per channel and a global threshold. The block drives the same g_interrupt / g_interrupt_1shot pair into ex_stage, and adds a claim/complete handshake plus a small word-addressed config/status register file reached over the DMA I/O bus.

## Interface
Parameters:
- NCH, 8: number of interrupt channels, 1..32; channel i has ID i+1, and ID 0 means "none".
- PRI_W, 3: priority width; priority 0 means never interrupt.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- irq_in  in  NCH  raw interrupt sources, asynchronous to clk.
- csr_meie  in  1  global machine external interrupt enable.
- interrupt_clear  in  1  legacy pulse; clears every edge-mode pending bit.
- cfg_we  in  1  config write strobe.
- cfg_wadr  in  6  config word write address.
- cfg_wdata  in  32  config write data.
- cfg_radr  in  6  config word read address.
- cfg_rdata  out  32  read data, registered.
- claim_re  in  1  claim strobe, one cycle.
- claim_id  out  6  claimed ID, registered; 0 when nothing was pending.
- complete_we  in  1  completion strobe.
- complete_id  in  6  ID being completed.
- g_interrupt  out  1  interrupt request level to the core.
- g_interrupt_1shot  out  1  one-cycle pulse on each rising edge of g_interrupt.

## Operation
Register map (word address):
- 0x00: enable bitmap.
- 0x01: mode bitmap (1 = edge, 0 = level).
- 0x02: threshold, PRI_W bits.
- 0x03: pending; read-only, except that writing 1 clears an edge-mode pending bit.
- 0x04: in-service bitmap, read-only.
- 0x10+i: priority of channel i.
- Bits above NCH/PRI_W read 0. Unmapped addresses read 0 and ignore writes.

Gateway, per channel:
- Two-flop synchroniser, then s3 holds the previous synchronised value.
- Edge mode: pending sets on s2 & ~s3.
- Level mode: pending follows s2.

Eligibility and arbitration:
- A channel is eligible when it is pending, enabled, not in service, and its priority is non-zero.
- Combinational arbitration selects the highest priority among eligible channels; ties go to the lowest index.
- best_id/best_pri are registered.
- g_interrupt register takes csr_meie & (arbitrated pri > threshold).

Claim and complete:
- Claim: claim_id is loaded with best_id. If that ID is non-zero, its in-service bit is set and its edge pending bit is cleared.
- Complete: the in-service bit is cleared. Ignored if the ID is 0, greater than NCH, or not currently in service.

Simultaneous events:
- A new edge in the same cycle as a claim of that channel: the set wins, so the channel is pending again once completed.
- Claim and complete of the same ID in the same cycle: in-service stays set.
- interrupt_clear together with a new edge: the set wins.
- A cfg write-1-clear together with a new edge: the set wins.

Reset values:
- All registers 0; g_interrupt, g_interrupt_1shot, claim_id and cfg_rdata are 0.
- The synchroniser flops are 0.
- Sources are disabled until software configures them.

## Timing
- With irq_in high before edge E0: s2 is valid after E1, pending is set at E2, and g_interrupt and best_id are set at E3. g_interrupt_1shot is high only during the cycle after E3.
- Claim strobe at edge C: claim_id is valid after C. g_interrupt can drop at C+1 at the earliest, because eligibility updates at C.
- cfg_rdata appears one cycle after cfg_radr.
- A config write takes effect on the arbitration seen at the next edge.
- A reset assertion at any time clears everything asynchronously. Pending interrupts are lost; level sources re-assert after 3 cycles.
- g_interrupt_1shot never fires twice without g_interrupt first dropping.

## Structure
- The shared defines file holds:
  - the register addresses 0x00–0x04 and the priority base 0x10;
  - ID width 6;
  - the NONE_ID = 0 constant.
- Sub-module irq_gateway contains the synchroniser, edge detect and pending/in-service flops. It is generated NCH times.
- The top level holds the config registers, the arbitration tree and the claim/complete logic.

## Test plan
- Reset only: all outputs 0, cfg_rdata 0 at every address, and a toggling irq_in has no effect.
- Channel 2, edge mode, priority 3, threshold 0, meie=1, single pulse on irq_in[2]: g_interrupt high 4 edges later and 1shot high for exactly one cycle. Claim returns ID 3 and g_interrupt drops. Complete ID 3 with no re-raise.
- Channels 1 and 5 both pending at priority 4, plus channel 6 at priority 2: claim order is 2, 6, 7. With threshold 3, channel 6 alone does not raise g_interrupt.
- Level source held high, claimed then completed: g_interrupt re-asserts 1 cycle after completion. Dropping the source before completion leaves no re-raise.
- Edge on channel 0 in the same cycle as a claim of ID 1: after complete ID 1, g_interrupt re-asserts and the next claim returns 1.
- Bad complete IDs (0, NCH+1, not in service) leave the in-service bitmap unchanged. interrupt_clear wipes pending 0x03 to 0. Reset mid-service clears 0x04.
